// File: rtl/vga_cpu_write_buffer_if.sv
// CPU-side bus bundle for the VGA write buffer:
// strobes, address/data in, ready and read data back.
interface vga_cpu_write_buffer_if;
  logic        _vga_mem;
  logic        _rd;
  logic        _wr;
  logic        _bhe;
  logic [16:0] addr;
  logic [15:0] wdata;
  logic        rdy;
  logic [15:0] rdata;

  modport master (
    output _vga_mem, _rd, _wr, _bhe, addr, wdata,
    input  rdy, rdata
  );

  modport slave (
    input  _vga_mem, _rd, _wr, _bhe, addr, wdata,
    output rdy, rdata
  );
endinterface

// File: rtl/vga_cpu_write_buffer.sv
// Posted-write queue and slot scheduler for CPU access
// to the 4-bank VGA SRAM; writes retire in idle fetch slots.
module vga_cpu_write_buffer #(
  parameter int DEPTH    = 4,
  parameter int WE_WIDTH = 2
) (
  input  logic                        clock,
  input  logic                        _reset,
  vga_cpu_write_buffer_if.slave       cpu,
  input  logic                        slot_grant,
  output logic                        ram_req,
  output logic [14:0]                 ram_addr,
  output logic [3:0]                  _cs_ram,
  output logic [3:0]                  _we_ram,
  output logic                        ram_dir,
  output logic [15:0]                 ram_wdata,
  input  logic [15:0]                 ram_rdata,
  output logic [2:0]                  fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [3:0] {
    IDLE, W1, W2, W3, W4, R1, R2, R3, R4
  } state_t;

  // addr[0] is kept so the low-bank select survives queueing
  typedef struct packed {
    logic [16:0] addr;
    logic        bhe;
    logic [15:0] data;
  } entry_t;

  state_t state_q, state_d;
  logic [2:0] vga_q, vga_d, rd_q, rd_d, wr_q, wr_d;
  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  entry_t hold_q, hold_d, head, push_entry;
  logic wreq_q, wreq_d;
  logic [16:0] raddr_q, raddr_d;
  logic rbhe_q, rbhe_d, rpend_q, rpend_d;
  logic rdy_q, rdy_d;
  logic [15:0] rdata_q, rdata_d;
  logic wr_fall, rd_fall, full, push_req, push, pop, rd_done;
  logic [3:0] wcs, rcs;
  logic [4:0] lvl_ext;

  function automatic logic [3:0] sel(
    input logic a1, input logic a0, input logic bhe
  );
    return a1 ? {bhe, a0, 2'b11} : {2'b11, bhe, a0};
  endfunction

  assign head       = mem_q[rptr_q];
  assign wcs        = sel(head.addr[1], head.addr[0], head.bhe);
  assign rcs        = sel(raddr_q[1], raddr_q[0], rbhe_q);
  assign wr_fall    = wr_q[2] & ~wr_q[1] & ~vga_q[1];
  assign rd_fall    = rd_q[2] & ~rd_q[1] & ~vga_q[1];
  assign full       = level_q == LW'(DEPTH);
  assign push_req   = wreq_q | wr_fall;
  assign push       = push_req & (~full | pop);
  assign push_entry = wreq_q ? hold_q
                    : {cpu.addr, cpu._bhe, cpu.wdata};
  assign lvl_ext    = 5'(level_q);
  assign fifo_level = (lvl_ext > 5'd7) ? 3'd7 : lvl_ext[2:0];
  assign cpu.rdy    = rdy_q;
  assign cpu.rdata  = rdata_q;

  // slot sequencer: RAM control outputs decoded from state
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    rd_done   = 1'b0;
    ram_req   = 1'b0;
    ram_dir   = 1'b1;
    ram_addr  = '0;
    _cs_ram   = 4'hF;
    _we_ram   = 4'hF;
    ram_wdata = '0;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (slot_grant) begin
          if (level_q != '0)  state_d = W1;
          else if (rpend_q)   state_d = R1;
        end
      end
      W1, W2, W3, W4: begin
        ram_req   = 1'b1;
        ram_addr  = head.addr[16:2];
        _cs_ram   = wcs;
        ram_wdata = head.data;
        if (state_q == W2 ||
            (state_q == W3 && WE_WIDTH > 1))
          _we_ram = wcs;
        case (state_q)
          W1:      state_d = W2;
          W2:      state_d = W3;
          W3:      state_d = W4;
          default: begin
            pop     = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
      R1, R2, R3: begin
        ram_req  = 1'b1;
        ram_dir  = 1'b0;
        ram_addr = raddr_q[16:2];
        _cs_ram  = rcs;
        case (state_q)
          R1:      state_d = R2;
          R2:      state_d = R3;
          default: begin
            rdata_d = ram_rdata;
            state_d = R4;
          end
        endcase
      end
      R4: begin
        ram_req  = 1'b1;
        ram_dir  = 1'b0;
        ram_addr = raddr_q[16:2];
        rd_done  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // strobe sync, queue bookkeeping and CPU ready
  always_comb begin
    vga_d   = {vga_q[1:0], cpu._vga_mem};
    rd_d    = {rd_q[1:0], cpu._rd};
    wr_d    = {wr_q[1:0], cpu._wr};
    mem_d   = mem_q;
    hold_d  = hold_q;
    wreq_d  = wreq_q;
    rdy_d   = rdy_q;
    raddr_d = raddr_q;
    rbhe_d  = rbhe_q;
    rpend_d = rpend_q;
    if (push) mem_d[wptr_q] = push_entry;
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
    if (push_req & ~push) begin
      wreq_d = 1'b1;
      rdy_d  = 1'b0;
      if (!wreq_q) hold_d = push_entry;
    end
    if (push) begin
      wreq_d = 1'b0;
      if (wreq_q) rdy_d = 1'b1;
    end
    if (rd_done) begin
      rpend_d = 1'b0;
      rdy_d   = 1'b1;
    end
    if (rd_fall) begin
      rpend_d = 1'b1;
      raddr_d = cpu.addr;
      rbhe_d  = cpu._bhe;
      rdy_d   = 1'b0;
    end
  end

  // state registers, async reset aborts any slot in flight
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q <= IDLE;
      vga_q   <= 3'b111;
      rd_q    <= 3'b111;
      wr_q    <= 3'b111;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      hold_q  <= '0;
      wreq_q  <= 1'b0;
      raddr_q <= '0;
      rbhe_q  <= 1'b1;
      rpend_q <= 1'b0;
      rdy_q   <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      vga_q   <= vga_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      wreq_q  <= wreq_d;
      raddr_q <= raddr_d;
      rbhe_q  <= rbhe_d;
      rpend_q <= rpend_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
